// File: rtl/cfu_cmd_issuer.sv
// CFU command initiator: buffers host requests in a FIFO, issues them one at a time over the
// cmd/rsp interface, and holds each response (or a watchdog abort) on the result port.
module cfu_cmd_issuer #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [9:0]  req_function_id,
   input  logic [31:0] req_inputs_0,
   input  logic [31:0] req_inputs_1,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_output,
   output logic        res_timeout,
   output logic        busy,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [9:0]  cmd_payload_function_id,
   output logic [31:0] cmd_payload_inputs_0,
   output logic [31:0] cmd_payload_inputs_1,
   input  logic        rsp_valid,
   output logic        rsp_ready,
   input  logic [31:0] rsp_payload_outputs_0
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

   state_t state, state_nxt;

   logic [9:0]  fifo_id  [FIFO_DEPTH];
   logic [31:0] fifo_in0 [FIFO_DEPTH];
   logic [31:0] fifo_in1 [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        empty, full, push, pop;
   logic        load_cmd, capture, abort, timeout_hit;
   logic [CW-1:0] wd_cnt;

   // Handshakes: a transfer happens on any rising edge where valid and ready are both high;
   // valid, once raised, holds with stable payload until that edge.

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign req_ready = !full || pop;
   assign push      = req_valid && req_ready;

   assign cmd_valid   = (state == ST_ISSUE);
   assign rsp_ready   = (state == ST_ISSUE) || (state == ST_WAIT);
   assign res_valid   = (state == ST_RESP);
   assign busy        = !empty || (state != ST_IDLE);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // A response captured in the same cycle as the timeout takes precedence over the abort.
   always_comb begin
      state_nxt = state;
      load_cmd  = 1'b0;
      capture   = 1'b0;
      abort     = 1'b0;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty) begin
               load_cmd  = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (cmd_ready && rsp_valid) begin
               capture   = 1'b1;
               pop       = 1'b1;
               state_nxt = ST_RESP;
            end else if (timeout_hit) begin
               abort     = 1'b1;
               pop       = 1'b1;
               state_nxt = ST_RESP;
            end else if (cmd_ready) begin
               pop       = 1'b1;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (rsp_valid) begin
               capture   = 1'b1;
               state_nxt = ST_RESP;
            end else if (timeout_hit) begin
               abort     = 1'b1;
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (res_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_id[wr_ptr[AW-1:0]]  <= req_function_id;
         fifo_in0[wr_ptr[AW-1:0]] <= req_inputs_0;
         fifo_in1[wr_ptr[AW-1:0]] <= req_inputs_1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_payload_function_id <= '0;
         cmd_payload_inputs_0    <= '0;
         cmd_payload_inputs_1    <= '0;
      end else if (load_cmd) begin
         cmd_payload_function_id <= fifo_id[rd_ptr[AW-1:0]];
         cmd_payload_inputs_0    <= fifo_in0[rd_ptr[AW-1:0]];
         cmd_payload_inputs_1    <= fifo_in1[rd_ptr[AW-1:0]];
      end
   end

   // Watchdog counts every cycle spent in ISSUE or WAIT and sticks at its maximum.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt <= '0;
      end else if (load_cmd) begin
         wd_cnt <= '0;
      end else if (rsp_ready && (wd_cnt != CNT_MAX)) begin
         wd_cnt <= wd_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_output  <= '0;
         res_timeout <= 1'b0;
      end else if (capture) begin
         res_output  <= rsp_payload_outputs_0;
         res_timeout <= 1'b0;
      end else if (abort) begin
         res_output  <= '0;
         res_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cfu_cmd_issuer.sv
// Randomized scoreboard bench for cfu_cmd_issuer with a scheduled CFU responder model.
module tb_cfu_cmd_issuer;
   localparam int T     = 8;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [9:0]  req_function_id;
   logic [31:0] req_inputs_0, req_inputs_1;
   logic        res_valid, res_ready;
   logic [31:0] res_output;
   logic        res_timeout, busy;
   logic        cmd_valid, cmd_ready;
   logic [9:0]  cmd_payload_function_id;
   logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_payload_outputs_0;

   logic        comb_mode, sched_cmd_ready, sched_rsp_valid, stray_rsp, hold_res;
   logic [31:0] sched_out;

   logic [32:0] exp_q[$];
   int          c_q[$];
   int          r_q[$];
   int          n_vec = 0;
   int          n_err = 0;

   // responder state
   bit          cfu_active;
   int          cfu_k, cfu_c, cfu_r, cfu_end, cfu_ncv, cfu_nrr;
   logic [31:0] cfu_pay;

   cfu_cmd_issuer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_function_id(req_function_id), .req_inputs_0(req_inputs_0), .req_inputs_1(req_inputs_1),
      .res_valid(res_valid), .res_ready(res_ready), .res_output(res_output),
      .res_timeout(res_timeout), .busy(busy),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_payload_function_id(cmd_payload_function_id),
      .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0)
   );

   assign cmd_ready = comb_mode ? rsp_ready : sched_cmd_ready;
   assign rsp_valid = comb_mode ? cmd_valid : (sched_rsp_valid | stray_rsp);
   assign rsp_payload_outputs_0 = comb_mode ?
      ((cmd_payload_function_id == 10'd0) ? 32'h0000_0001 : 32'hFFFF_FFFF) : sched_out;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "bench time limit reached");
   end

   // ---------------- helpers ----------------
   function automatic logic [31:0] cfu_fn(logic [9:0] id, logic [31:0] a, logic [31:0] b);
      return (a + {b[15:0], b[31:16]}) ^ {22'd0, id};
   endfunction

   function automatic int imin(int a, int b);
      return (a < b) ? a : b;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_req(input logic [9:0] id, input logic [31:0] a, input logic [31:0] b,
                           input int c, input int r, output int waited);
      waited = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_function_id = id;
      req_inputs_0 = a;
      req_inputs_1 = b;
      #1;
      while (!req_ready && waited < 200) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!req_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL push_stall: req_ready still 0 after %0d cycles, required 1", waited);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (comb_mode) begin
         exp_q.push_back({1'b0, (id == 10'd0) ? 32'h0000_0001 : 32'hFFFF_FFFF});
      end else begin
         // completion must land on watchdog count T-1 or earlier
         if (c + r >= T) exp_q.push_back({1'b1, 32'h0});
         else            exp_q.push_back({1'b0, cfu_fn(id, a, b)});
         c_q.push_back(c);
         r_q.push_back(r);
      end
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while ((busy || exp_q.size() != 0 || cfu_active) && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("drain_busy", busy, 0);
      check("drain_pending", exp_q.size(), 0);
   endtask

   // ---------------- CFU responder model ----------------
   initial begin
      sched_cmd_ready = 1'b0;
      sched_rsp_valid = 1'b0;
      sched_out       = 32'h0;
      cfu_active      = 1'b0;
      forever begin
         @(negedge clk);
         if (rst || comb_mode) begin
            cfu_active      = 1'b0;
            sched_cmd_ready = 1'b0;
            sched_rsp_valid = 1'b0;
            continue;
         end
         if (!cfu_active && cmd_valid) begin
            if (c_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL extra_command: cmd_valid=1 with no request outstanding");
               continue;
            end
            cfu_c = c_q.pop_front();
            cfu_r = r_q.pop_front();
            cfu_k = 0;
            cfu_ncv = 0;
            cfu_nrr = 0;
            cfu_pay = cfu_fn(cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1);
            cfu_end = (cfu_c + cfu_r <= T - 1) ? cfu_c + cfu_r : T + 1;
            cfu_active = 1'b1;
         end
         if (cfu_active) begin
            if (cmd_valid) cfu_ncv++;
            if (rsp_ready) cfu_nrr++;
            sched_cmd_ready = (cfu_k == cfu_c);
            sched_rsp_valid = (cfu_k == cfu_c + cfu_r);
            sched_out       = cfu_pay;
            if (cfu_k == cfu_end) begin
               cfu_active = 1'b0;
               check("cmd_valid_cycles", cfu_ncv, imin(cfu_c, T - 1) + 1);
               check("rsp_ready_cycles", cfu_nrr, imin(cfu_c + cfu_r, T - 1) + 1);
            end
            cfu_k++;
         end else begin
            sched_cmd_ready = 1'b0;
            sched_rsp_valid = 1'b0;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [32:0] e;
      res_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            res_ready = 1'b0;
            continue;
         end
         if (res_valid && !hold_res && ($urandom_range(0, 9) < 7)) begin
            res_ready = 1'b1;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_result: got to=%0d out=0x%0h, required none",
                        res_timeout, res_output);
            end else begin
               e = exp_q.pop_front();
               check("result", {res_timeout, res_output}, e);
            end
         end else begin
            res_ready = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int w, c, r;
      rst = 1'b1;
      req_valid = 1'b0;
      req_function_id = '0;
      req_inputs_0 = '0;
      req_inputs_1 = '0;
      comb_mode = 1'b0;
      stray_rsp = 1'b0;
      hold_res  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_rsp_ready", rsp_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_res", {res_timeout, res_output}, 0);
      check("rst_payload", {cmd_payload_function_id, cmd_payload_inputs_0}, 0);
      rst = 1'b0;

      // combinational CFU
      comb_mode = 1'b1;
      push_req(10'd0, 32'h1234, 32'h5678, 0, 0, w);
      push_req(10'd5, 32'h9abc, 32'hdef0, 0, 0, w);
      wait_idle();
      comb_mode = 1'b0;

      // FIFO fills while the head command stalls; results held back
      hold_res = 1'b1;
      push_req(10'd1, 32'h11, 32'h22, 5, 0, w);
      for (int i = 0; i < 3; i++) push_req(10'(i + 2), $urandom(), $urandom(), 0, 1, w);
      check("full_req_ready", req_ready, 0);
      check("full_busy", busy, 1);
      push_req(10'd9, 32'h99, 32'h98, 0, 1, w);
      check("fifth_push_wait", w, 3);
      repeat (4) @(negedge clk);
      check("held_res_valid", res_valid, 1);
      hold_res = 1'b0;
      wait_idle();

      // command never accepted -> abort; then a normal one
      push_req(10'd3, 32'hAAAA, 32'hBBBB, T + 1, 0, w);
      push_req(10'd4, 32'hCCCC, 32'hDDDD, 1, 1, w);
      wait_idle();

      // accepted at once, answer 3 cycles later
      push_req(10'd0, 32'hDEADBEEF, 32'h0, 0, 3, w);
      wait_idle();

      // completion exactly on the timeout cycle, and just past it
      push_req(10'd7, $urandom(), $urandom(), 2, T - 3, w);
      push_req(10'd8, $urandom(), $urandom(), T - 1, 0, w);
      push_req(10'd9, $urandom(), $urandom(), 3, T - 3, w);
      push_req(10'd10, $urandom(), $urandom(), T - 1, 1, w);
      wait_idle();

      // stray response while idle
      @(negedge clk);
      stray_rsp = 1'b1;
      @(negedge clk);
      stray_rsp = 1'b0;
      repeat (3) @(negedge clk);
      check("stray_res_valid", res_valid, 0);
      check("stray_busy", busy, 0);

      // random traffic
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         c = $urandom_range(0, T + 1);
         r = $urandom_range(0, T + 1 - c);
         push_req(10'($urandom_range(0, 1023)), $urandom(), $urandom(), c, r, w);
      end
      wait_idle();

      // reset while waiting for a response with two entries behind it
      push_req(10'd1, 32'h1, 32'h2, 0, T + 1, w);
      push_req(10'd2, 32'h3, 32'h4, 0, 0, w);
      push_req(10'd3, 32'h5, 32'h6, 0, 0, w);
      w = 0;
      while (!(rsp_ready && !cmd_valid) && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("wait_reached", {cmd_valid, rsp_ready}, 2'b01);
      check("wait_busy", busy, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_cmd_valid", cmd_valid, 0);
      check("mid_rst_rsp_ready", rsp_ready, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_req_ready", req_ready, 1);
      check("mid_rst_res", {res_valid, res_timeout, res_output}, 0);
      exp_q.delete();
      c_q.delete();
      r_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_res_valid", res_valid, 0);
      check("post_rst_cmd_valid", cmd_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
